// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM states, the
// mul/div watchdog counter width and the bundled stage-register controls.
package pipeline_ctrl_pkg;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } pctl_state_t;

    localparam int MD_CNT_W = 8;

    // Per-stage register controls (the PC hold is carried separately).
    typedef struct packed {
        logic if_id_freeze;
        logic if_id_flush;
        logic id_ex_freeze;
        logic id_ex_flush;
        logic ex_mem_freeze;
        logic ex_mem_flush;
        logic mem_wb_flush;
    } stage_ctrl_t;

    // A load in EX feeding a source of the instruction in ID; x0 never hazards.
    function automatic logic load_use_hazard(
        input logic       ex_mem_read,
        input logic [4:0] ex_rd,
        input logic [4:0] id_rs1,
        input logic [4:0] id_rs2
    );
        return ex_mem_read && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    endfunction

endpackage

// File: rtl/pipeline_ctrl_event_counter.sv
// Free-running event counter that wraps modulo 2^W; cleared by synchronous reset.
module event_counter
    import pipeline_ctrl_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer: merges mem wait, redirect, mul/div occupancy
// and load-use hazards into per-stage controls; owns the mul/div handshake.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Mem_memAccess,
    input  logic             dmem_ready,
    input  logic             Ex_jump_or_branch,
    input  logic             Ex_muldiv,
    input  logic             md_done,
    input  logic             Ex_memRead,
    input  logic [4:0]       Ex_RegRd,
    input  logic [4:0]       ID_RegRs1,
    input  logic [4:0]       ID_RegRs2,
    output logic             pc_freeze,
    output logic             IF_ID_freeze,
    output logic             IF_ID_flush,
    output logic             ID_Ex_freeze,
    output logic             ID_Ex_flush,
    output logic             Ex_Mem_freeze,
    output logic             Ex_Mem_flush,
    output logic             Mem_Wb_flush,
    output logic             md_start,
    output logic             md_error,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [MD_CNT_W-1:0] MD_TIMEOUT_C = MD_TIMEOUT[MD_CNT_W-1:0];

    pctl_state_t         state_q, state_d;
    logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic                md_error_q, md_error_d;

    stage_ctrl_t ctrl;
    logic        pc_freeze_c;
    logic        md_start_c;
    logic        redirect_fire;
    logic        mem_wait;

    assign mem_wait = Mem_memAccess && !dmem_ready;

    always_comb begin
        ctrl          = '0;
        pc_freeze_c   = 1'b0;
        md_start_c    = 1'b0;
        redirect_fire = 1'b0;
        state_d       = state_q;
        md_cnt_d      = md_cnt_q;
        md_error_d    = md_error_q;

        // Reset forces every control low, even with a mul/div outstanding.
        if (!rst) begin
            unique case (state_q)
                RUN: begin
                    if (mem_wait) begin
                        pc_freeze_c        = 1'b1;
                        ctrl.if_id_freeze  = 1'b1;
                        ctrl.id_ex_freeze  = 1'b1;
                        ctrl.ex_mem_freeze = 1'b1;
                        ctrl.mem_wb_flush  = 1'b1;
                    end else if (Ex_jump_or_branch) begin
                        redirect_fire    = 1'b1;
                        ctrl.if_id_flush = 1'b1;
                        ctrl.id_ex_flush = 1'b1;
                    end else if (Ex_muldiv) begin
                        md_start_c        = 1'b1;
                        pc_freeze_c       = 1'b1;
                        ctrl.if_id_freeze = 1'b1;
                        ctrl.id_ex_freeze = 1'b1;
                        ctrl.ex_mem_flush = 1'b1;
                        state_d           = MD_BUSY;
                        md_cnt_d          = {{(MD_CNT_W-1){1'b0}}, 1'b1};
                    end else if (load_use_hazard(Ex_memRead, Ex_RegRd, ID_RegRs1, ID_RegRs2)) begin
                        pc_freeze_c       = 1'b1;
                        ctrl.if_id_freeze = 1'b1;
                        ctrl.id_ex_flush  = 1'b1;
                    end
                end
                MD_BUSY: begin
                    if (md_done) begin
                        state_d = RUN;
                    end else if (md_cnt_q < MD_TIMEOUT_C) begin
                        pc_freeze_c       = 1'b1;
                        ctrl.if_id_freeze = 1'b1;
                        ctrl.id_ex_freeze = 1'b1;
                        ctrl.ex_mem_flush = 1'b1;
                        md_cnt_d          = md_cnt_q + 1'b1;
                    end else begin
                        md_error_d = 1'b1;
                        state_d    = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            md_cnt_q   <= '0;
            md_error_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            md_cnt_q   <= md_cnt_d;
            md_error_q <= md_error_d;
        end
    end

    event_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (pc_freeze_c && !redirect_fire),
        .count (stall_cycles)
    );

    event_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (redirect_fire),
        .count (flush_count)
    );

    assign pc_freeze     = pc_freeze_c;
    assign IF_ID_freeze  = ctrl.if_id_freeze;
    assign IF_ID_flush   = ctrl.if_id_flush;
    assign ID_Ex_freeze  = ctrl.id_ex_freeze;
    assign ID_Ex_flush   = ctrl.id_ex_flush;
    assign Ex_Mem_freeze = ctrl.ex_mem_freeze;
    assign Ex_Mem_flush  = ctrl.ex_mem_flush;
    assign Mem_Wb_flush  = ctrl.mem_wb_flush;
    assign md_start      = md_start_c;
    assign md_error      = md_error_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: hazard priorities, mul/div handshake,
// watchdog, reset during mul/div and counter wrap (MD_TIMEOUT=8, CNT_W=4).
module tb_pipeline_ctrl;

    localparam int CNT_W = 4;

    // Control vector: {pc_freeze, IF_ID_freeze, IF_ID_flush, ID_Ex_freeze,
    //                  ID_Ex_flush, Ex_Mem_freeze, Ex_Mem_flush, Mem_Wb_flush, md_start}
    localparam logic [8:0] C_NONE  = 9'b0_0_0_0_0_0_0_0_0;
    localparam logic [8:0] C_MEMW  = 9'b1_1_0_1_0_1_0_1_0;
    localparam logic [8:0] C_REDIR = 9'b0_0_1_0_1_0_0_0_0;
    localparam logic [8:0] C_MDST  = 9'b1_1_0_1_0_0_1_0_1;
    localparam logic [8:0] C_MDBSY = 9'b1_1_0_1_0_0_1_0_0;
    localparam logic [8:0] C_LU    = 9'b1_1_0_0_1_0_0_0_0;

    logic             clk = 1'b0;
    logic             rst;
    logic             Mem_memAccess, dmem_ready, Ex_jump_or_branch, Ex_muldiv, md_done, Ex_memRead;
    logic [4:0]       Ex_RegRd, ID_RegRs1, ID_RegRs2;
    logic             pc_freeze, IF_ID_freeze, IF_ID_flush, ID_Ex_freeze, ID_Ex_flush;
    logic             Ex_Mem_freeze, Ex_Mem_flush, Mem_Wb_flush, md_start, md_error;
    logic [CNT_W-1:0] stall_cycles, flush_count;
    logic [8:0]       ctl;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.MD_TIMEOUT(8), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .Mem_memAccess(Mem_memAccess), .dmem_ready(dmem_ready),
        .Ex_jump_or_branch(Ex_jump_or_branch), .Ex_muldiv(Ex_muldiv),
        .md_done(md_done), .Ex_memRead(Ex_memRead), .Ex_RegRd(Ex_RegRd),
        .ID_RegRs1(ID_RegRs1), .ID_RegRs2(ID_RegRs2),
        .pc_freeze(pc_freeze), .IF_ID_freeze(IF_ID_freeze), .IF_ID_flush(IF_ID_flush),
        .ID_Ex_freeze(ID_Ex_freeze), .ID_Ex_flush(ID_Ex_flush),
        .Ex_Mem_freeze(Ex_Mem_freeze), .Ex_Mem_flush(Ex_Mem_flush),
        .Mem_Wb_flush(Mem_Wb_flush), .md_start(md_start), .md_error(md_error),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    assign ctl = {pc_freeze, IF_ID_freeze, IF_ID_flush, ID_Ex_freeze, ID_Ex_flush,
                  Ex_Mem_freeze, Ex_Mem_flush, Mem_Wb_flush, md_start};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic idle_inputs();
        Mem_memAccess = 0; dmem_ready = 1; Ex_jump_or_branch = 0; Ex_muldiv = 0;
        md_done = 0; Ex_memRead = 0; Ex_RegRd = 0; ID_RegRs1 = 0; ID_RegRs2 = 0;
    endtask

    // Inputs change 1 ns after the edge; outputs are sampled 2 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick();

        // Reset state: controls forced low even with hazards present.
        Mem_memAccess = 1; dmem_ready = 0; Ex_muldiv = 1;
        settle();
        check("rst_ctl", 32'(ctl), 32'(C_NONE));
        check("rst_stall", 32'(stall_cycles), 32'd0);
        check("rst_flush", 32'(flush_count), 32'd0);
        check("rst_err", 32'(md_error), 32'd0);
        do_reset();

        // Load-use via rs2, then x0 (no hazard), then via rs1.
        Ex_memRead = 1; Ex_RegRd = 5; ID_RegRs2 = 5; settle();
        check("lu_rs2_ctl", 32'(ctl), 32'(C_LU));
        tick();
        check("lu_stall1", 32'(stall_cycles), 32'd1);
        Ex_RegRd = 0; ID_RegRs2 = 0; settle();
        check("lu_x0_ctl", 32'(ctl), 32'(C_NONE));
        tick();
        check("lu_x0_stall", 32'(stall_cycles), 32'd1);
        Ex_RegRd = 7; ID_RegRs1 = 7; settle();
        check("lu_rs1_ctl", 32'(ctl), 32'(C_LU));
        tick();
        check("lu_stall2", 32'(stall_cycles), 32'd2);

        // Mul/div: start, 3 busy cycles (Ex_muldiv held, must not restart), done.
        do_reset();
        Ex_muldiv = 1; settle();
        check("md_start_ctl", 32'(ctl), 32'(C_MDST));
        for (int i = 1; i <= 3; i++) begin
            tick(); settle();
            check($sformatf("md_busy%0d_ctl", i), 32'(ctl), 32'(C_MDBSY));
        end
        tick(); Ex_muldiv = 0; md_done = 1; settle();
        check("md_done_ctl", 32'(ctl), 32'(C_NONE));
        tick(); settle();
        check("md_stall4", 32'(stall_cycles), 32'd4);
        check("md_done_in_run", 32'(ctl), 32'(C_NONE));
        check("md_noerr", 32'(md_error), 32'd0);
        md_done = 0;

        // Watchdog: no md_done, release on MD_BUSY cycle 8.
        do_reset();
        Ex_muldiv = 1; settle();
        check("wd_start_ctl", 32'(ctl), 32'(C_MDST));
        tick(); Ex_muldiv = 0;
        for (int i = 1; i <= 7; i++) begin
            settle();
            check($sformatf("wd_busy%0d_ctl", i), 32'(ctl), 32'(C_MDBSY));
            tick();
        end
        settle();
        check("wd_release_ctl", 32'(ctl), 32'(C_NONE));
        check("wd_err_before", 32'(md_error), 32'd0);
        tick(); tick(); tick(); settle();
        check("wd_err_sticky", 32'(md_error), 32'd1);
        check("wd_stall8", 32'(stall_cycles), 32'd8);
        check("wd_run_after", 32'(ctl), 32'(C_NONE));
        do_reset(); settle();
        check("wd_err_cleared", 32'(md_error), 32'd0);

        // Mem wait holding a redirect for 3 cycles, then the redirect fires once.
        Mem_memAccess = 1; dmem_ready = 0; Ex_jump_or_branch = 1;
        for (int i = 1; i <= 3; i++) begin
            settle();
            check($sformatf("mw_%0d_ctl", i), 32'(ctl), 32'(C_MEMW));
            tick();
            check($sformatf("mw_%0d_flush", i), 32'(flush_count), 32'd0);
        end
        dmem_ready = 1; settle();
        check("mw_redir_ctl", 32'(ctl), 32'(C_REDIR));
        tick();
        check("mw_flush1", 32'(flush_count), 32'd1);
        check("mw_stall3", 32'(stall_cycles), 32'd3);
        Mem_memAccess = 0; Ex_muldiv = 1; settle();
        check("redir_over_md", 32'(ctl), 32'(C_REDIR));
        tick();
        check("mw_flush2", 32'(flush_count), 32'd2);
        Ex_jump_or_branch = 0; Ex_muldiv = 0;

        // Reset on MD_BUSY cycle 2, then a late md_done must be ignored.
        do_reset();
        Ex_muldiv = 1; tick(); settle();
        check("rmd_busy1", 32'(ctl), 32'(C_MDBSY));
        tick(); rst = 1; settle();
        check("rmd_rst_ctl", 32'(ctl), 32'(C_NONE));
        tick(); rst = 0; Ex_muldiv = 0;
        check("rmd_stall0", 32'(stall_cycles), 32'd0);
        check("rmd_flush0", 32'(flush_count), 32'd0);
        md_done = 1; settle();
        check("rmd_late_done", 32'(ctl), 32'(C_NONE));
        tick(); md_done = 0;
        Mem_memAccess = 1; dmem_ready = 0; settle();
        check("rmd_in_run", 32'(ctl), 32'(C_MEMW));
        tick();
        check("rmd_stall1", 32'(stall_cycles), 32'd1);

        // Counter wrap: 17 load-use stalls in a 4-bit counter leave 1.
        do_reset();
        Ex_memRead = 1; Ex_RegRd = 3; ID_RegRs1 = 3;
        for (int i = 0; i < 17; i++) tick();
        check("wrap_stall", 32'(stall_cycles), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
